// File: rtl/pipe_skid_16bit.sv
// ---------------------------------------------------------------------------
// pipe_skid_16bit
//
// Two-entry skid buffer. It fully decouples a valid/ready producer from a
// valid/ready consumer. The consumer always sees data from the main
// register. The skid register catches the one word that arrives while the
// main register is stalled.
//
// Ports
//   clk        rising-edge clock for all state.
//   rst        synchronous active-high reset. It has priority over
//              everything else.
//   flush      synchronous active-high discard of all buffered words.
//   in_valid   producer presents in_data this cycle.
//   in_data    producer word, SIZE bits.
//   in_ready   buffer can accept this cycle. It depends only on registered
//              state and flush, and never on out_ready.
//   out_valid  out_data holds a valid word.
//   out_data   word at the head of the buffer. It comes straight from the
//              main register.
//   out_ready  consumer accepts this cycle.
//   count      occupancy, 0..2, registered.
// ---------------------------------------------------------------------------
module pipe_skid_16bit #(
    parameter int SIZE = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    input  logic [SIZE-1:0] in_data,
    output logic            in_ready,
    output logic            out_valid,
    output logic [SIZE-1:0] out_data,
    input  logic            out_ready,
    output logic [1:0]      count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [SIZE-1:0] main_reg;
    logic [SIZE-1:0] main_next;
    logic [SIZE-1:0] skid_reg;
    logic [SIZE-1:0] skid_next;

    // These status flags are registered copies decoded from the next state.
    // The handshake outputs therefore come straight from flops.
    logic            valid_reg;
    logic            space_reg;
    logic [1:0]      count_reg;

    logic            in_fire;
    logic            out_fire;

    assign in_ready  = space_reg & ~flush;
    assign out_valid = valid_reg;
    assign out_data  = main_reg;
    assign count     = count_reg;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = valid_reg & out_ready;

    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        if (flush) begin
            // A word consumed in this cycle is simply gone. Nothing is
            // captured from in_data, because in_ready is forced low.
            state_next = EMPTY;
            main_next  = '0;
            skid_next  = '0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (in_fire) begin
                        main_next  = in_data;
                        state_next = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_next = in_data;
                    end else if (in_fire) begin
                        skid_next  = in_data;
                        state_next = TWO;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the drain can happen.
                    if (out_fire) begin
                        main_next  = skid_reg;
                        state_next = ONE;
                    end
                end
                default: begin
                    state_next = EMPTY;
                    main_next  = '0;
                    skid_next  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= EMPTY;
            main_reg  <= '0;
            skid_reg  <= '0;
            valid_reg <= 1'b0;
            space_reg <= 1'b1;
            count_reg <= 2'd0;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
            skid_reg  <= skid_next;
            valid_reg <= (state_next != EMPTY);
            space_reg <= (state_next != TWO);
            count_reg <= state_next;
        end
    end

endmodule
